axis_pattern_gen: RTL and testbench
===================================

# axis_pattern_gen

Parametrised AXI4-Stream traffic source that generates framed packets of configurable length, count, inter-packet gap and data pattern. It is the next generation of the fixed-length stream master that feeds the `mac` transmit path, with selectable width, patterns, back-pressure handling and status counters. It sits on the MAC's `s_axis_*` side in bench and bring-up builds, clocked by the MAC's `tx_data_clk`.

## Interface
- DATA_WIDTH, 8, tdata width; legal range 1..32.
- LEN_WIDTH, 16, width of `pkt_len`.
- GAP_WIDTH, 16, width of `gap`.
- LFSR_SEED, 32'hACE1_0001, LFSR value after reset; must be non-zero.

- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- enable  in  1  level; high starts/continues generation.
- mode  in  2  0 = incrementing, 1 = constant, 2 = LFSR, 3 = walking-one.
- pkt_len  in  LEN_WIDTH  beats per packet; 0 is treated as 1.
- pkt_count  in  16  packets per run; 0 = unlimited.
- gap  in  GAP_WIDTH  idle cycles between packets.
- const_val  in  DATA_WIDTH  data for mode 1.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  last beat of packet.
- m_axis_tuser  out  1  first beat of packet (SOF).
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when a run of `pkt_count` packets completes.
- pkt_sent  out  32  packets fully accepted since reset; wraps at 2^32.

## Operation
- States: IDLE, SEND, GAP.
- IDLE:
  - With `enable` high: latch mode, pkt_len, pkt_count, gap and const_val; clear the beat counter; load the pattern start value; go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - tvalid is high.
  - A beat is accepted when tvalid and tready are both high.
  - tdata, tlast and tuser stay stable while tvalid && !tready.
  - tuser is high on beat 0 only. tlast is high on beat pkt_len−1. With pkt_len ≤ 1, tuser and tlast are both high on the single beat.
  - On acceptance of the last beat:
    - pkt_sent +1; the run counter +1.
    - If pkt_count ≠ 0 and the run counter reaches pkt_count: pulse done, go to IDLE.
    - Else if enable is low: go to IDLE. Generation stops only on packet boundaries; no truncated packets.
    - Else if gap = 0: reload the latched config and stay in SEND. The next beat 0 follows with no bubble.
    - Else: go to GAP.
- GAP:
  - tvalid is low.
  - Count exactly `gap` cycles, then:
    - enable high: relatch config and go to SEND.
    - enable low: go to IDLE.
- Config changes take effect only at packet starts.
- The run counter clears on entry to SEND from IDLE.
- Patterns (the pattern advances only on accepted beats):
  - inc: starts at 0 each packet, +1 per beat, wraps mod 2^DATA_WIDTH.
  - const: const_val on every beat.
  - LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1; tdata = lfsr[DATA_WIDTH−1:0]. The LFSR is not reset between packets or runs, only by resetn.
  - walking-one: starts at bit 0 each packet, rotates left by 1 per beat.
- Beat counter width is LEN_WIDTH. Gap counter width is GAP_WIDTH. pkt_len = 2^LEN_WIDTH−1 is legal.

## Timing
- Reset (resetn low at a clk edge): state IDLE; tvalid, tlast, tuser, busy and done = 0; tdata = 0; pkt_sent = 0; LFSR = LFSR_SEED.
- Reset mid-packet: the stream drops at that edge with no tlast. The downstream sees a truncated packet; this is accepted behaviour.
- Start latency: enable sampled high at edge N in IDLE → tvalid and tuser high after edge N.
- Throughput: with tready held high, one beat per cycle.
- Gap: exactly `gap` low-tvalid cycles between the last-beat acceptance and the next beat 0.
- done: asserted for the single cycle after the edge that accepts the final beat; busy falls on that same edge.
- pkt_sent updates on the edge that accepts tlast.
- Simultaneous events:
  - enable falling in the same cycle as the last-beat acceptance: go to IDLE.
  - enable falling during GAP: go to IDLE at the end of the gap, not earlier.

## Test plan
- mode 0, pkt_len 4, pkt_count 2, gap 3, tready = 1 → packets 00,01,02,03 with tuser on 00 and tlast on 03; then 3 idle cycles; then a second identical packet; then done pulses once; pkt_sent = 2; busy low.
- mode 0, pkt_len 8, tready toggling 1,0,0,1… → tdata/tlast/tuser hold while stalled; accepted sequence 00..07 with no duplicates or skips.
- mode 2, DATA_WIDTH 8, pkt_len 16, gap 0, pkt_count 3 → 48 back-to-back beats with no tvalid gap; data matches a reference LFSR seeded 32'hACE1_0001; after a reset the same sequence repeats.
- mode 3, DATA_WIDTH 4, pkt_len 6 → 1,2,4,8,1,2; tlast on beat 5.
- pkt_len 0, mode 1, const_val 8'h5A → single-beat packets 5A with tuser and tlast both high.
- enable low mid-packet (beat 3 of 10), pkt_count 0 → packet completes through beat 9 with tlast, then IDLE. Separately, resetn low mid-packet → tvalid 0 on the next edge and pkt_sent = 0.

Source files
------------

// File: rtl/axis_pattern_gen.sv
// AXI4-Stream framed packet source (inc/const/LFSR/walking-one); first beat one cycle after enable seen in IDLE.
// Outputs come straight from registers and hold while tvalid && !tready; stops only on packet boundaries.
module axis_pattern_gen #(
    parameter int          DATA_WIDTH = 8,
    parameter int          LEN_WIDTH  = 16,
    parameter int          GAP_WIDTH  = 16,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_0001
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [15:0]           pkt_count,
    input  logic [GAP_WIDTH-1:0]  gap,
    input  logic [DATA_WIDTH-1:0] const_val,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           pkt_sent
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam logic [1:0]            MODE_INC   = 2'd0;
    localparam logic [1:0]            MODE_CONST = 2'd1;
    localparam logic [1:0]            MODE_LFSR  = 2'd2;
    localparam logic [1:0]            MODE_WALK  = 2'd3;
    // Right-shifting Galois form of x^32+x^22+x^2+x+1
    localparam logic [31:0]           LFSR_TAPS  = 32'h8020_0003;
    localparam logic [DATA_WIDTH-1:0] ONE_DAT    = DATA_WIDTH'(1);

    state_t                state, state_nxt;
    logic [1:0]            cfg_mode;
    logic [LEN_WIDTH-1:0]  cfg_last;
    logic [15:0]           cfg_count;
    logic [GAP_WIDTH-1:0]  cfg_gap;
    logic [DATA_WIDTH-1:0] cfg_const;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic [15:0]           run_cnt;
    logic [GAP_WIDTH-1:0]  gap_cnt;
    logic [DATA_WIDTH-1:0] data_q;
    logic [31:0]           lfsr;
    logic [31:0]           pkt_sent_q;
    logic                  done_q;

    logic                  accept, is_last, last_acc, run_done, lfsr_adv;
    logic [15:0]           run_cnt_inc;
    logic [31:0]           lfsr_next;
    logic [DATA_WIDTH-1:0] start_data, adv_data;
    logic                  pkt_start, run_clear, gap_load;

    assign accept      = (state == SEND) && m_axis_tready;
    assign is_last     = (beat_cnt == cfg_last);
    assign last_acc    = accept && is_last;
    assign run_cnt_inc = run_cnt + 16'd1;
    assign run_done    = last_acc && (cfg_count != 16'd0) && (run_cnt_inc == cfg_count);
    assign lfsr_adv    = accept && (cfg_mode == MODE_LFSR);
    assign lfsr_next   = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'd0);

    // Start value uses the freshly sampled mode; a back-to-back packet must see the already-stepped LFSR
    always_comb begin
        start_data = '0;
        case (mode)
            MODE_INC:   start_data = '0;
            MODE_CONST: start_data = const_val;
            MODE_LFSR:  start_data = lfsr_adv ? lfsr_next[DATA_WIDTH-1:0] : lfsr[DATA_WIDTH-1:0];
            MODE_WALK:  start_data = ONE_DAT;
            default:    start_data = '0;
        endcase
    end

    always_comb begin
        adv_data = data_q;
        case (cfg_mode)
            MODE_INC:   adv_data = data_q + ONE_DAT;
            MODE_CONST: adv_data = cfg_const;
            MODE_LFSR:  adv_data = lfsr_next[DATA_WIDTH-1:0];
            MODE_WALK:  adv_data = (data_q << 1) | (data_q >> (DATA_WIDTH - 1));
            default:    adv_data = data_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pkt_start = 1'b0;
        run_clear = 1'b0;
        gap_load  = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = SEND;
                    pkt_start = 1'b1;
                    run_clear = 1'b1;
                end
            end
            SEND: begin
                if (last_acc) begin
                    if (run_done || !enable) begin
                        state_nxt = IDLE;
                    end else if (cfg_gap == '0) begin
                        pkt_start = 1'b1;
                    end else begin
                        state_nxt = GAP;
                        gap_load  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    if (enable) begin
                        state_nxt = SEND;
                        pkt_start = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cfg_mode   <= MODE_INC;
            cfg_last   <= '0;
            cfg_count  <= '0;
            cfg_gap    <= '0;
            cfg_const  <= '0;
            beat_cnt   <= '0;
            run_cnt    <= '0;
            gap_cnt    <= '0;
            data_q     <= '0;
            lfsr       <= LFSR_SEED;
            pkt_sent_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= run_done;
            if (lfsr_adv) begin
                lfsr <= lfsr_next;
            end
            if (last_acc) begin
                pkt_sent_q <= pkt_sent_q + 32'd1;
                run_cnt    <= run_cnt_inc;
            end
            if (pkt_start) begin
                cfg_mode  <= mode;
                cfg_last  <= (pkt_len == '0) ? '0 : pkt_len - LEN_WIDTH'(1);
                cfg_count <= pkt_count;
                cfg_gap   <= gap;
                cfg_const <= const_val;
                beat_cnt  <= '0;
                data_q    <= start_data;
                if (run_clear) begin
                    run_cnt <= '0;
                end
            end else if (accept) begin
                beat_cnt <= beat_cnt + LEN_WIDTH'(1);
                data_q   <= adv_data;
            end
            if (gap_load) begin
                gap_cnt <= cfg_gap - GAP_WIDTH'(1);
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - GAP_WIDTH'(1);
            end
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = (state == SEND);
    assign m_axis_tuser  = (state == SEND) && (beat_cnt == '0);
    assign m_axis_tlast  = (state == SEND) && is_last;
    assign busy          = (state != IDLE);
    assign done          = done_q;
    assign pkt_sent      = pkt_sent_q;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Directed bench for axis_pattern_gen: an 8-bit instance for most scenarios, a 4-bit instance for walking-one.
module tb_axis_pattern_gen;

    logic        clk = 1'b0;
    logic        resetn, enable, enable4, tready;
    logic [1:0]  mode;
    logic [15:0] pkt_len, pkt_count, gap;
    logic [7:0]  const_val;
    logic [3:0]  const4;

    logic [7:0]  tdata;
    logic        tvalid, tlast, tuser, busy, done;
    logic [31:0] pkt_sent;
    logic [3:0]  tdata4;
    logic        tvalid4, tlast4, tuser4, busy4, done4;
    logic [31:0] pkt_sent4;

    int checks = 0;
    int failures = 0;
    int exp_sent = 0;

    always #5 clk = ~clk;

    axis_pattern_gen #(.DATA_WIDTH(8)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .mode(mode),
        .pkt_len(pkt_len), .pkt_count(pkt_count), .gap(gap), .const_val(const_val),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast), .m_axis_tuser(tuser),
        .busy(busy), .done(done), .pkt_sent(pkt_sent)
    );

    axis_pattern_gen #(.DATA_WIDTH(4)) dut4 (
        .clk(clk), .resetn(resetn), .enable(enable4), .mode(mode),
        .pkt_len(pkt_len), .pkt_count(pkt_count), .gap(gap), .const_val(const4),
        .m_axis_tdata(tdata4), .m_axis_tvalid(tvalid4), .m_axis_tready(tready),
        .m_axis_tlast(tlast4), .m_axis_tuser(tuser4),
        .busy(busy4), .done(done4), .pkt_sent(pkt_sent4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        lfsr_step = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    task automatic test_reset;
        logic [12:0] act;
        resetn = 1'b0; enable = 1'b0; enable4 = 1'b0; tready = 1'b1;
        mode = 2'd0; pkt_len = 16'd1; pkt_count = 16'd0; gap = 16'd0;
        const_val = 8'h00; const4 = 4'h0;
        tick; tick;
        act = {tvalid, tlast, tuser, busy, done, tdata};
        checks++;
        if (act !== 13'd0) begin
            failures++; $display("FAIL reset_outputs: got %h expected %h", act, 13'd0);
        end
        checks++;
        if (pkt_sent !== 32'd0) begin
            failures++; $display("FAIL reset_pkt_sent: got %0d expected 0", pkt_sent);
        end
        resetn = 1'b1;
        tick;
        checks++;
        if ({tvalid, busy} !== 2'b00) begin
            failures++; $display("FAIL idle_without_enable: got %b expected 00", {tvalid, busy});
        end
    endtask

    // Two 4-beat incrementing packets, 3-cycle gap, then done
    task automatic test_basic;
        logic [12:0] act, exp_v;
        logic        v;
        int          b;
        mode = 2'd0; pkt_len = 16'd4; pkt_count = 16'd2; gap = 16'd3; tready = 1'b1; enable = 1'b1;
        for (int c = 0; c < 13; c++) begin
            tick;
            if (c == 11) enable = 1'b0;
            v = (c < 4) || (c >= 7 && c <= 10);
            b = (c < 4) ? c : c - 7;
            exp_v = {v, v && b == 0, v && b == 3, c <= 10, c == 11, v ? 8'(b) : 8'h00};
            act   = {tvalid, tuser, tlast, busy, done, tvalid ? tdata : 8'h00};
            checks++;
            if (act !== exp_v) begin
                failures++; $display("FAIL basic_cycle%0d: got %h expected %h", c, act, exp_v);
            end
        end
        exp_sent += 2;
        checks++;
        if (pkt_sent !== 32'(exp_sent)) begin
            failures++; $display("FAIL basic_pkt_sent: got %0d expected %0d", pkt_sent, exp_sent);
        end
    endtask

    task automatic test_stall;
        logic [10:0] act, exp_v;
        int          idx = 0;
        int          cyc = 0;
        mode = 2'd0; pkt_len = 16'd8; pkt_count = 16'd1; gap = 16'd0; tready = 1'b1; enable = 1'b1;
        tick;
        enable = 1'b0;
        while (idx < 8 && cyc < 60) begin
            tready = (cyc % 3 == 0);
            act   = {tvalid, tuser, tlast, tdata};
            exp_v = {1'b1, idx == 0, idx == 7, 8'(idx)};
            checks++;
            if (act !== exp_v) begin
                failures++; $display("FAIL stall_cycle%0d: got %h expected %h", cyc, act, exp_v);
            end
            if (tready) idx++;
            cyc++;
            tick;
        end
        tready = 1'b1;
        checks++;
        if (idx != 8) begin
            failures++; $display("FAIL stall_timeout: got %0d beats expected 8", idx);
        end
        checks++;
        if ({done, tvalid, busy} !== 3'b100) begin
            failures++; $display("FAIL stall_done: got %b expected 100", {done, tvalid, busy});
        end
        exp_sent += 1;
        checks++;
        if (pkt_sent !== 32'(exp_sent)) begin
            failures++; $display("FAIL stall_pkt_sent: got %0d expected %0d", pkt_sent, exp_sent);
        end
    endtask

    task automatic test_walk;
        logic [3:0] w [6];
        logic [6:0] act, exp_v;
        w = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
        mode = 2'd3; pkt_len = 16'd6; pkt_count = 16'd1; gap = 16'd0; tready = 1'b1; enable4 = 1'b1;
        tick;
        enable4 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            act   = {tvalid4, tuser4, tlast4, tdata4};
            exp_v = {1'b1, c == 0, c == 5, w[c]};
            checks++;
            if (act !== exp_v) begin
                failures++; $display("FAIL walk_beat%0d: got %h expected %h", c, act, exp_v);
            end
            tick;
        end
        checks++;
        if ({done4, tvalid4, tvalid} !== 3'b100) begin
            failures++; $display("FAIL walk_done: got %b expected 100", {done4, tvalid4, tvalid});
        end
    endtask

    task automatic test_single;
        logic [10:0] act;
        mode = 2'd1; pkt_len = 16'd0; pkt_count = 16'd3; gap = 16'd0; const_val = 8'h5A;
        tready = 1'b1; enable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            act = {tvalid, tuser, tlast, tdata};
            checks++;
            if (act !== {3'b111, 8'h5A}) begin
                failures++; $display("FAIL single_beat%0d: got %h expected %h", c, act, {3'b111, 8'h5A});
            end
        end
        tick;
        enable = 1'b0;
        checks++;
        if ({done, tvalid} !== 2'b10) begin
            failures++; $display("FAIL single_done: got %b expected 10", {done, tvalid});
        end
        exp_sent += 3;
        checks++;
        if (pkt_sent !== 32'(exp_sent)) begin
            failures++; $display("FAIL single_pkt_sent: got %0d expected %0d", pkt_sent, exp_sent);
        end
    endtask

    // enable drops during beat 3 of 10: the packet still finishes, then IDLE
    task automatic test_enable_stop;
        logic [11:0] act, exp_v;
        logic        v;
        mode = 2'd0; pkt_len = 16'd10; pkt_count = 16'd0; gap = 16'd2; tready = 1'b1; enable = 1'b1;
        for (int c = 0; c < 13; c++) begin
            tick;
            if (c == 3) enable = 1'b0;
            v = (c <= 9);
            exp_v = {v, v && c == 0, v && c == 9, v, v ? 8'(c) : 8'h00};
            act   = {tvalid, tuser, tlast, busy, tvalid ? tdata : 8'h00};
            checks++;
            if (act !== exp_v) begin
                failures++; $display("FAIL enstop_cycle%0d: got %h expected %h", c, act, exp_v);
            end
        end
        exp_sent += 1;
        checks++;
        if (pkt_sent !== 32'(exp_sent)) begin
            failures++; $display("FAIL enstop_pkt_sent: got %0d expected %0d", pkt_sent, exp_sent);
        end
    endtask

    // 48 back-to-back LFSR beats, repeated after reset
    task automatic test_lfsr;
        logic [7:0]  cap [48];
        logic [31:0] l;
        logic [10:0] act, exp_v;
        for (int run = 0; run < 2; run++) begin
            resetn = 1'b0; enable = 1'b0;
            tick;
            resetn = 1'b1;
            exp_sent = 0;
            mode = 2'd2; pkt_len = 16'd16; pkt_count = 16'd3; gap = 16'd0; tready = 1'b1; enable = 1'b1;
            l = 32'hACE1_0001;
            for (int c = 0; c < 48; c++) begin
                tick;
                act   = {tvalid, tuser, tlast, tdata};
                exp_v = {1'b1, c % 16 == 0, c % 16 == 15, l[7:0]};
                checks++;
                if (act !== exp_v) begin
                    failures++; $display("FAIL lfsr_run%0d_beat%0d: got %h expected %h", run, c, act, exp_v);
                end
                l = lfsr_step(l);
                if (run == 0) begin
                    cap[c] = tdata;
                end else if (c < 8) begin
                    checks++;
                    if (tdata !== cap[c]) begin
                        failures++; $display("FAIL lfsr_repeat_beat%0d: got %h expected %h", c, tdata, cap[c]);
                    end
                end
            end
            tick;
            enable = 1'b0;
            checks++;
            if ({done, tvalid} !== 2'b10) begin
                failures++; $display("FAIL lfsr_done_run%0d: got %b expected 10", run, {done, tvalid});
            end
        end
        checks++;
        if ({cap[0], cap[1], cap[2], cap[3]} !== 32'h0103_0201) begin
            failures++; $display("FAIL lfsr_first_beats: got %h expected 01030201", {cap[0], cap[1], cap[2], cap[3]});
        end
        exp_sent = 3;
        checks++;
        if (pkt_sent !== 32'(exp_sent)) begin
            failures++; $display("FAIL lfsr_pkt_sent: got %0d expected %0d", pkt_sent, exp_sent);
        end
    endtask

    task automatic test_reset_mid;
        mode = 2'd0; pkt_len = 16'd10; pkt_count = 16'd0; gap = 16'd0; tready = 1'b1; enable = 1'b1;
        tick; tick; tick;
        checks++;
        if ({tvalid, tdata} !== {1'b1, 8'h02}) begin
            failures++; $display("FAIL rstmid_pre: got %h expected 102", {tvalid, tdata});
        end
        resetn = 1'b0; enable = 1'b0;
        tick;
        checks++;
        if ({tvalid, tlast, busy, tdata} !== 11'd0) begin
            failures++; $display("FAIL rstmid_outputs: got %h expected 000", {tvalid, tlast, busy, tdata});
        end
        checks++;
        if (pkt_sent !== 32'd0) begin
            failures++; $display("FAIL rstmid_pkt_sent: got %0d expected 0", pkt_sent);
        end
        resetn = 1'b1;
        exp_sent = 0;
        tick;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_walk;
        test_single;
        test_enable_stop;
        test_lfsr;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
